if_fetch_unit: RTL

//  Instruction-fetch stage of the 5-stage MIPS pipeline; producer side of the IF->ID interface.

---
 rtl/if_fetch_unit_pkg.sv | 51 +++++
 rtl/if_fetch_unit_fetch_fifo.sv | 54 +++++
 rtl/if_fetch_unit.sv | 100 ++++++++++
 3 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the IF stage: instruction class codes, MIPS opcodes,
// fetch FSM encodings, the prefetch entry layout and the class decoder.
package if_fetch_unit_pkg;

  localparam logic [3:0] INST_TYPE_NONE   = 4'd0;
  localparam logic [3:0] INST_TYPE_R      = 4'd1;
  localparam logic [3:0] INST_TYPE_I      = 4'd2;
  localparam logic [3:0] INST_TYPE_LOAD   = 4'd3;
  localparam logic [3:0] INST_TYPE_STORE  = 4'd4;
  localparam logic [3:0] INST_TYPE_BRANCH = 4'd5;
  localparam logic [3:0] INST_TYPE_JUMP   = 4'd6;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
    logic [3:0]  seq;
  } fetch_entry_t;

  function automatic logic [3:0] decode_type(input logic [5:0] op, input logic [5:0] funct);
    logic [3:0] t;
    t = INST_TYPE_NONE;
    case (op)
      OP_SPECIAL: t = (funct == FN_JR || funct == FN_JALR) ? INST_TYPE_JUMP : INST_TYPE_R;
      OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: t = INST_TYPE_BRANCH;
      OP_J, OP_JAL: t = INST_TYPE_JUMP;
      default: begin
        // 0x08-0x0F immediate ALU, 0x20-0x26 loads, stores incl. swr
        if (op[5:3] == 3'b001) t = INST_TYPE_I;
        else if (op[5:3] == 3'b100 && op != 6'h27) t = INST_TYPE_LOAD;
        else if (op inside {6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E}) t = INST_TYPE_STORE;
      end
    endcase
    return t;
  endfunction

endpackage

// File: rtl/if_fetch_unit_fetch_fifo.sv
// Prefetch FIFO for fetched words; head entry is read combinationally so a
// word is visible to ID the cycle after it is written.
module if_fetch_unit_fetch_fifo
  import if_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]  count_reg;
  logic           do_push, do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !flush && (!full || pop);
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr_reg];
  assign count   = count_reg;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// MIPS instruction-fetch stage: owns the PC, issues one-outstanding memory
// reads, buffers words in a prefetch FIFO and presents the head to ID.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_stall,
  input  logic        id_redirect,
  input  logic [31:0] id_new_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc4,
  output logic        if_valid,
  output logic [3:0]  if_ins_type,
  output logic [3:0]  if_ins_number
);
  localparam int             CW        = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]  DEPTH_CNT = CW'(DEPTH);

  logic [1:0]    state_reg, state_next;
  logic [31:0]   pc_reg, pc_next;
  logic [3:0]    seq_reg, seq_next;
  fetch_entry_t  head, push_entry;
  logic [CW-1:0] count, count_after;
  logic          full, empty, push_en, pop_en, present;

  assign pop_en      = !empty && !id_stall && !id_redirect;
  assign push_en     = (state_reg == ST_REQ) && imem_ack && !id_redirect && (!full || pop_en);
  assign count_after = count + CW'(push_en) - CW'(pop_en);
  assign push_entry  = '{inst: imem_rdata, pc4: pc_reg + 32'd4, seq: seq_reg};

  if_fetch_unit_fetch_fifo #(.DEPTH(DEPTH)) u_fetch_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_en),
    .push_data (push_entry),
    .pop       (pop_en),
    .flush     (id_redirect),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    seq_next   = seq_reg;
    if (id_redirect) begin
      // A request still in flight must be drained without being enqueued.
      pc_next    = id_new_pc & 32'hFFFF_FFFC;
      state_next = ((state_reg == ST_REQ || state_reg == ST_DISCARD) && !imem_ack)
                   ? ST_DISCARD : ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: if (count < DEPTH_CNT) state_next = ST_REQ;
        ST_REQ: begin
          if (imem_ack) begin
            pc_next    = pc_reg + 32'd4;
            seq_next   = seq_reg + 4'd1;
            state_next = (count_after < DEPTH_CNT) ? ST_REQ : ST_IDLE;
          end
        end
        ST_DISCARD: if (imem_ack) state_next = (count_after < DEPTH_CNT) ? ST_REQ : ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      pc_reg    <= RESET_PC;
      seq_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      seq_reg   <= seq_next;
    end
  end

  assign imem_req  = (state_reg == ST_REQ);
  assign imem_addr = pc_reg;

  // Redirect cycle forces a bubble so ID latches a nop.
  assign present       = !empty && !id_redirect;
  assign if_valid      = present;
  assign if_inst       = present ? head.inst : 32'd0;
  assign if_pc4        = present ? head.pc4 : 32'd0;
  assign if_ins_number = present ? head.seq : 4'd0;
  assign if_ins_type   = present ? decode_type(head.inst[31:26], head.inst[5:0]) : INST_TYPE_NONE;

endmodule
